// File: rtl/reg8_access_arbiter_pkg.sv
// Shared types and defaults for the reg8 access arbiter.
package reg8_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, CHECK} arb_state_t;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/reg8_access_arbiter_if.sv
// Requester-side bus of the reg8 access arbiter: requests, write data, grant and read-back.
interface reg8_access_arbiter_if
  import reg8_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = DW_DEF
);

  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0][DW-1:0] wdata;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rvalid;
  logic [DW-1:0]            rdata;

  modport master (output req, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/reg8_access_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IW-1:0]    winner_idx_o
);

  localparam logic [IW:0] NReq = (IW+1)'(N_REQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    found        = 1'b0;
    sum          = '0;
    cand         = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // Modular add keeps non-power-of-two N_REQ correct.
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= NReq) sum = sum - NReq;
      cand = sum[IW-1:0];
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        winner_idx_o = cand;
      end
    end
    winner_o[winner_idx_o] = found;
  end

endmodule

// File: rtl/reg8_access_arbiter.sv
// Shares one reg8 register between N_REQ requesters: round-robin write, read-back check,
// sticky mismatch flag and completed-transaction counter.
module reg8_access_arbiter
  import reg8_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg8_access_arbiter_if.slave bus,
  output logic [DW-1:0]        reg_d,
  input  logic [DW-1:0]        reg_q,
  output logic                 err,
  output logic [CNT_W-1:0]     txn_cnt
);

  localparam int unsigned IW      = $clog2(N_REQ);
  localparam logic [IW-1:0] LastIdx = IW'(N_REQ - 1);

  arb_state_t state_q, state_d;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    reg_d_q, reg_d_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr_arbiter (
    .req_i       (bus.req),
    .ptr_i       (ptr_q),
    .winner_o    (win_oh),
    .winner_idx_o(win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|bus.req) state_d = WRITE;
      WRITE:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    reg_d_d  = reg_d_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          gnt_d   = win_oh;
          idx_d   = win_idx;
          // reg_d doubles as the latched copy used for the read-back compare.
          reg_d_d = bus.wdata[win_idx];
          ptr_d   = (win_idx == LastIdx) ? '0 : win_idx + IW'(1);
        end
      end
      WRITE: ;
      CHECK: begin
        gnt_d    = '0;
        rvalid_d = N_REQ'(1) << idx_q;
        rdata_d  = reg_q;
        cnt_d    = cnt_q + CNT_W'(1);
        err_d    = err_q | (reg_q != reg_d_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      reg_d_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      reg_d_q  <= reg_d_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign reg_d      = reg_d_q;
  assign err        = err_q;
  assign txn_cnt    = cnt_q;

endmodule

// File: tb/tb_reg8_access_arbiter.sv
// Bench for reg8_access_arbiter: directed scenarios plus random requesters, checked against a
// transaction-level model every cycle.
module tb_reg8_access_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg8_access_arbiter_if #(.N_REQ(N), .DW(W)) bus ();

  logic [W-1:0]  reg_d;
  logic [W-1:0]  reg_q = '0;
  logic          err;
  logic [CW-1:0] txn_cnt;
  logic          force_zero = 1'b0;

  reg8_access_arbiter #(
    .N_REQ(N),
    .DW   (W),
    .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .reg_d  (reg_d),
    .reg_q  (reg_q),
    .err    (err),
    .txn_cnt(txn_cnt)
  );

  // reg8 stand-in; force_zero models a stuck-at-zero register.
  always @(posedge clk) reg_q <= force_zero ? '0 : reg_d;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transaction occupies three edges (grant, write, check).
  int            m_ptr, m_step, m_win;
  logic [W-1:0]  m_data;
  logic [N-1:0]  e_gnt, e_rvalid;
  logic [W-1:0]  e_rdata, e_regd;
  logic          e_err;
  logic [CW-1:0] e_cnt;

  task automatic model_reset();
    m_ptr = 0; m_step = 0; m_win = 0; m_data = '0;
    e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_regd = '0; e_err = 1'b0; e_cnt = '0;
  endtask

  task automatic model_edge();
    if (m_step == 0) begin
      e_rvalid = '0;
      e_gnt    = '0;
      for (int k = 0; k < N; k++) begin
        if (m_step == 0 && bus.req[2'((m_ptr + k) % N)]) begin
          m_win  = (m_ptr + k) % N;
          m_step = 1;
        end
      end
      if (m_step == 1) begin
        e_gnt  = 4'(1 << m_win);
        m_data = bus.wdata[2'(m_win)];
        e_regd = m_data;
        m_ptr  = (m_win + 1) % N;
      end
    end else if (m_step == 1) begin
      m_step = 2;
    end else begin
      e_rdata  = force_zero ? '0 : m_data;
      e_rvalid = 4'(1 << m_win);
      e_gnt    = '0;
      e_cnt    = 16'(e_cnt + 1);
      if (e_rdata != m_data) e_err = 1'b1;
      m_step = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("gnt", bus.gnt, e_gnt);
        chk("rvalid", bus.rvalid, e_rvalid);
        chk("rdata", bus.rdata, e_rdata);
        chk("reg_d", reg_d, e_regd);
        chk("err", err, e_err);
        chk("txn_cnt", txn_cnt, e_cnt);
      end
    end
  end

  task automatic do_reset();
    bus.req = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bounded wait for a specific rvalid pattern, sampled on negedges.
  task automatic wait_rv(input logic [N-1:0] mask, input string name);
    int n = 0;
    while (bus.rvalid !== mask && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.rvalid, mask);
  endtask

  logic [N-1:0] ord [5];
  logic [W-1:0] ord_d [5];

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_reg_d", reg_d, 0);
    chk("rst_err", err, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    rst_n = 1'b1;

    // Single request from requester 0.
    @(negedge clk);
    bus.wdata[0] = 8'hA5;
    bus.req      = 4'b0001;
    @(negedge clk);
    chk("t1_gnt_c1", bus.gnt, 4'b0001);
    @(negedge clk);
    chk("t1_gnt_c2", bus.gnt, 4'b0001);
    @(negedge clk);
    chk("t1_rvalid", bus.rvalid, 4'b0001);
    chk("t1_rdata", bus.rdata, 8'hA5);
    chk("t1_txn_cnt", txn_cnt, 1);
    chk("t1_err", err, 0);
    chk("t1_gnt_off", bus.gnt, 0);
    bus.req = '0;

    // All four requesting: strict round robin from pointer 0.
    do_reset();
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req   = 4'b1111;
    ord   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ord_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      wait_rv(ord[k], "t2_order");
      chk("t2_rdata", bus.rdata, ord_d[k]);
      if (k == 4) bus.req = '0;
      @(negedge clk);
    end

    // Requester 0 sweeps every data value.
    do_reset();
    bus.wdata[0] = 8'h00;
    bus.req      = 4'b0001;
    @(negedge clk);
    for (int v = 0; v < 256; v++) begin
      wait_rv(4'b0001, "t3_rvalid");
      chk("t3_rdata", bus.rdata, v);
      bus.wdata[0] = 8'(v + 1);
      if (v == 255) bus.req = '0;
      @(negedge clk);
    end
    chk("t3_txn_cnt", txn_cnt, 256);
    chk("t3_err", err, 0);

    // Stuck-at-zero register: err must latch and stay set.
    force_zero   = 1'b1;
    bus.wdata[0] = 8'h3C;
    bus.req      = 4'b0001;
    @(negedge clk);
    wait_rv(4'b0001, "t4_rvalid");
    chk("t4_rdata", bus.rdata, 8'h00);
    chk("t4_err", err, 1);
    force_zero   = 1'b0;
    bus.wdata[0] = 8'h5A;
    @(negedge clk);
    wait_rv(4'b0001, "t4_rvalid_ok1");
    chk("t4_rdata_ok1", bus.rdata, 8'h5A);
    @(negedge clk);
    wait_rv(4'b0001, "t4_rvalid_ok2");
    bus.req = '0;
    chk("t4_err_sticky", err, 1);
    chk("t4_txn_cnt", txn_cnt, 259);

    // Reset in the middle of a transaction.
    @(negedge clk);
    bus.wdata[0] = 8'h77;
    bus.req      = 4'b0001;
    @(negedge clk);
    chk("t5_gnt_pre", bus.gnt, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t5_gnt", bus.gnt, 0);
    chk("t5_rvalid", bus.rvalid, 0);
    chk("t5_reg_d", reg_d, 0);
    chk("t5_txn_cnt", txn_cnt, 0);
    chk("t5_err", err, 0);
    bus.req      = 4'b0100;
    bus.wdata[2] = 8'h99;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_gnt", bus.gnt, 4'b0100);
    wait_rv(4'b0100, "t5_rvalid2");
    chk("t5_rdata", bus.rdata, 8'h99);
    bus.req = '0;

    // Request dropped right after grant; another requester is waiting.
    @(negedge clk);
    bus.wdata[1] = 8'h61;
    bus.req      = 4'b0010;
    @(negedge clk);
    chk("t6_gnt", bus.gnt, 4'b0010);
    bus.req      = 4'b0001;
    bus.wdata[0] = 8'h62;
    wait_rv(4'b0010, "t6_rvalid");
    chk("t6_rdata", bus.rdata, 8'h61);
    @(negedge clk);
    chk("t6_next_gnt", bus.gnt, 4'b0001);
    chk("t6_single_pulse", bus.rvalid, 0);
    wait_rv(4'b0001, "t6_rvalid0");
    bus.req = '0;

    // Random requesters, including data changes after grant and early drops.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.rvalid[2'(i)]) begin
          if ($urandom_range(0, 1) == 0) bus.req[2'(i)] = 1'b0;
          else bus.wdata[2'(i)] = 8'($urandom);
        end else if (!bus.req[2'(i)]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.wdata[2'(i)] = 8'($urandom);
            bus.req[2'(i)]   = 1'b1;
          end
        end else if (bus.gnt[2'(i)]) begin
          if ($urandom_range(0, 3) == 0) bus.wdata[2'(i)] = 8'($urandom);
          if ($urandom_range(0, 15) == 0) bus.req[2'(i)] = 1'b0;
        end
      end
    end
    bus.req = '0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
